// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared width default, scheduler state encoding and clog2 helper
package accel_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Never returns less than 1 so it is always usable as a vector width
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first request at or after ptr wins
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin
        logic         found;
        int           j;
        logic [N-1:0] rot;
        grant = '0;
        found = 1'b0;
        j     = 0;
        rot   = '0;
        for (int i = 0; i < N; i++) begin
            j = i + int'(ptr);
            if (j >= N) j = j - N;
            rot = req >> j;
            if (!found && rot[0]) begin
                grant = N'(1) << j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - shares one bit-serial multiplier among round-robin requesters
module mult_sched
    import accel_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MULT_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_neuron,
    input  logic [NUM_REQ*WIDTH-1:0] req_weight,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     busy,
    output logic                     mult_reset,
    output logic                     mult_enable,
    output logic [WIDTH-1:0]         mult_input,
    output logic                     mult_weight_bit,
    input  logic [WIDTH-1:0]         mult_out
);

    localparam int CNT_W   = 5;
    localparam int SEL_W   = clog2(WIDTH);
    localparam int DRAIN_W = clog2(MULT_LAT + 1);

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      job_id;
    logic [ID_W-1:0]      gidx;
    logic [ID_W-1:0]      next_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [WIDTH-1:0]     weight_q;
    logic [WIDTH-1:0]     sel_neuron;
    logic [WIDTH-1:0]     sel_weight;
    logic [CNT_W-1:0]     bit_cnt;
    logic [SEL_W-1:0]     bit_sel_nxt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 can_grant;
    logic                 take;

    rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // A handshake in DONE frees the result buffer, so that cycle may grant like IDLE
    assign can_grant = !reset && ((state == S_IDLE) || (state == S_DONE && res_ready));
    assign take      = can_grant && (|req_valid);
    assign req_ready = take ? grant : '0;

    always_comb begin
        gidx       = '0;
        sel_neuron = '0;
        sel_weight = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gidx       = ID_W'(i);
                sel_neuron = req_neuron[i*WIDTH +: WIDTH];
                sel_weight = req_weight[i*WIDTH +: WIDTH];
            end
        end
    end

    assign next_ptr    = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
    assign bit_sel_nxt = bit_cnt[SEL_W-1:0] + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            ptr             <= '0;
            job_id          <= '0;
            weight_q        <= '0;
            bit_cnt         <= '0;
            drain_cnt       <= '0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            res_id          <= '0;
            busy            <= 1'b0;
            mult_reset      <= 1'b0;
            mult_enable     <= 1'b0;
            mult_input      <= '0;
            mult_weight_bit <= 1'b0;
        end else if (take) begin
            state           <= S_CLEAR;
            ptr             <= next_ptr;
            job_id          <= gidx;
            weight_q        <= sel_weight;
            mult_input      <= sel_neuron;
            bit_cnt         <= '0;
            drain_cnt       <= '0;
            res_valid       <= 1'b0;
            busy            <= 1'b1;
            mult_reset      <= 1'b0;
            mult_enable     <= 1'b0;
            mult_weight_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    busy        <= 1'b0;
                    mult_reset  <= 1'b1;
                    mult_enable <= 1'b0;
                end
                S_CLEAR: begin
                    state           <= S_SHIFT;
                    mult_reset      <= 1'b1;
                    mult_enable     <= 1'b1;
                    mult_weight_bit <= weight_q[0];
                    bit_cnt         <= '0;
                end
                S_SHIFT: begin
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state           <= S_DRAIN;
                        mult_weight_bit <= 1'b0;
                        drain_cnt       <= '0;
                    end else begin
                        bit_cnt         <= bit_cnt + CNT_W'(1);
                        mult_weight_bit <= weight_q[bit_sel_nxt];
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(MULT_LAT - 1)) begin
                        state       <= S_DONE;
                        res_valid   <= 1'b1;
                        res_data    <= mult_out;
                        res_id      <= job_id;
                        mult_enable <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
